mem_req_ctrl: RTL and testbench

Request controller that sits directly upstream of the single-port 64x64 SRAM `memory` block. It accepts write and read commands over a valid/ready handshake and issues at most one registered access per cycle on the memory's `addr_i`/`wdata_i`/`wr_en_i`/`rd_en_i` pins. It captures `rdata_o` into an in-order response FIFO that has its own valid/ready output. Read credits prevent any read data from being dropped under downstream backpressure.

---
 rtl/mem_req_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request controller in front of the single-port 64x64 SRAM.
// Accepts read/write commands over valid/ready, issues one registered access
// per cycle on the memory pins and returns read data through an in-order
// response FIFO. Read credits (issued + pending + buffered) are bounded by the
// FIFO depth so no read data can be lost under downstream backpressure.
//
// Build option: define MEM_CTRL_INIT_EN to add a CLEAR phase after reset that
// writes zero to every memory address before commands are accepted. Without
// it the memory's own reset is relied on and commands are accepted at once.

module mem_req_ctrl #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WIDTH-1:0]      cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  init_done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  input  logic [WIDTH-1:0]      mem_rdata_i
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic [0:0]            state;
  logic                  init_done;
  logic                  rd_pend;
  logic                  clr_write;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic [WIDTH-1:0]      fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic [1:0]            inflight;
  logic [31:0]           credits_used;
  logic                  cmd_fire;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits: every read in the issue stage or awaiting capture already owns
  // a FIFO slot. Only registered state feeds ready, so a same-cycle pop never
  // opens the gate early.
  assign inflight     = {1'b0, mem_rd_en_o} + {1'b0, rd_pend};
  assign credits_used = 32'(inflight) + 32'(fifo_count);
  assign cmd_ready_o  = init_done && (state == ST_RUN) && (credits_used < RSP_DEPTH);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;

  assign push        = rd_pend;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_valid_o = (fifo_count != '0);
  assign init_done_o = init_done;

`ifdef MEM_CTRL_INIT_EN
  // One extra count beyond the last address marks the end of the sweep.
  logic [ADDR_WIDTH:0] clr_cnt;

  assign clr_write = (state == ST_CLEAR) && (clr_cnt != (ADDR_WIDTH + 1)'(DEPTH));
  assign clr_addr  = clr_cnt[ADDR_WIDTH-1:0];

  // Sequencer: sweep all addresses once after reset, then enter RUN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_CLEAR;
      init_done <= 1'b0;
      clr_cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_write) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end
`else
  assign clr_write = 1'b0;
  assign clr_addr  = '0;

  // Sequencer: no clear sweep, ready from the first cycle after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end
`endif

  // Issue stage: present one access to the memory for exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wr_en_o <= 1'b0;
      mem_rd_en_o <= 1'b0;
    end else begin
      mem_wr_en_o <= 1'b0;
      mem_rd_en_o <= 1'b0;
      if (clr_write) begin
        mem_addr_o  <= clr_addr;
        mem_wdata_o <= '0;
        mem_wr_en_o <= 1'b1;
      end else if (cmd_fire) begin
        mem_addr_o  <= cmd_addr_i;
        mem_wdata_o <= cmd_we_i ? cmd_wdata_i : '0;
        mem_wr_en_o <= cmd_we_i;
        mem_rd_en_o <= !cmd_we_i;
      end
    end
  end

  // Capture stage: the memory returns data the cycle after a read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en_o;
    end
  end

  // Response FIFO bookkeeping; reset discards anything buffered or in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response FIFO storage.
  // NOTE: storage is not reset; occupancy lives in the count and pointers,
  // and the output is forced to zero whenever no entry is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata_i;
  end

  assign rsp_data_o = rsp_valid_o ? fifo_mem[rd_ptr] : '0;

`ifndef SYNTHESIS
  // Invariants guaranteed by the credit scheme and the issue stage.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && (fifo_count == CNT_W'(RSP_DEPTH))));
      assert (!(mem_wr_en_o && mem_rd_en_o));
      assert (32'(mem_addr_o) < DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed self-checking bench for mem_req_ctrl with a
// behavioural model of the 64x64 single-port SRAM hooked to the mem_* pins.

module tb_mem_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [5:0]  cmd_addr_i;
  logic [63:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic        init_done_o;
  logic [5:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_wr_en_o;
  logic        mem_rd_en_o;
  logic [63:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  logic [63:0] sram [64];
  logic [63:0] got_q [$];

  mem_req_ctrl #(
    .WIDTH(64), .DEPTH(64), .ADDR_WIDTH(6), .RSP_DEPTH(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .init_done_o (init_done_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: synchronous write, registered read, cleared by its own reset.
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) sram[i] <= '0;
      mem_rdata_i <= '0;
    end else begin
      if (mem_wr_en_o) sram[mem_addr_o] <= mem_wdata_o;
      if (mem_rd_en_o) mem_rdata_i <= sram[mem_addr_o];
    end
  end

  // Record every response handshake, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) got_q.push_back(rsp_data_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 64'hx;
  endfunction

  // Present one command and return #1 after the edge that accepts it.
  task automatic send(input logic we, input logic [5:0] addr, input logic [63:0] data);
    int budget = 200;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = data;
    while (!cmd_ready_o && budget > 0) begin
      step();
      budget--;
    end
    check("cmd_accept", {63'd0, cmd_ready_o}, 64'd1);
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_init();
    int budget = 200;
    while (!init_done_o && budget > 0) begin
      step();
      budget--;
    end
    check("init_wait", {63'd0, init_done_o}, 64'd1);
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_init_done", {63'd0, init_done_o}, 64'd0);
    check("rst_wr_en",     {63'd0, mem_wr_en_o}, 64'd0);
    check("rst_rd_en",     {63'd0, mem_rd_en_o}, 64'd0);
    check("rst_addr",      {58'd0, mem_addr_o},  64'd0);
    check("rst_rsp_data",  rsp_data_o,           64'd0);
    rst_i = 1'b0;

`ifdef MEM_CTRL_INIT_EN
    // Clear sweep: cycles 1..64 write zero to 0..63, RUN on cycle 65.
    for (int i = 0; i < 64; i++) begin
      step();
      check("clr_ready", {63'd0, cmd_ready_o}, 64'd0);
      check("clr_done",  {63'd0, init_done_o}, 64'd0);
      check("clr_wr_en", {63'd0, mem_wr_en_o}, 64'd1);
      check("clr_addr",  {58'd0, mem_addr_o},  64'(i));
      check("clr_wdata", mem_wdata_o,          64'd0);
    end
    step();
    check("clr_end_done",  {63'd0, init_done_o}, 64'd1);
    check("clr_end_ready", {63'd0, cmd_ready_o}, 64'd1);
    check("clr_end_wr_en", {63'd0, mem_wr_en_o}, 64'd0);
`else
    step();
    check("run_init_done", {63'd0, init_done_o}, 64'd1);
    check("run_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
`endif

    // Write addr 5 then read it back on the next cycle.
    send(1'b1, 6'd5, 64'hDEADBEEF01234567);
    check("wr_en_issue",  {63'd0, mem_wr_en_o}, 64'd1);
    check("wr_rd_en_low", {63'd0, mem_rd_en_o}, 64'd0);
    check("wr_addr",      {58'd0, mem_addr_o},  64'd5);
    check("wr_data",      mem_wdata_o,          64'hDEADBEEF01234567);
    send(1'b0, 6'd5, 64'd0);
    check("rd_en_issue",  {63'd0, mem_rd_en_o}, 64'd1);
    check("rd_wr_en_low", {63'd0, mem_wr_en_o}, 64'd0);
    check("rd_addr",      {58'd0, mem_addr_o},  64'd5);
    check("rd_lat_e0",    {63'd0, rsp_valid_o}, 64'd0);
    step();
    check("rd_lat_e1",    {63'd0, rsp_valid_o}, 64'd0);
    step();
    check("rd_lat_e2",    {63'd0, rsp_valid_o}, 64'd1);
    check("rd_data",      rsp_data_o,           64'hDEADBEEF01234567);
    repeat (2) step();
    check("rd_hold_valid", {63'd0, rsp_valid_o}, 64'd1);
    check("rd_hold_data",  rsp_data_o,           64'hDEADBEEF01234567);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check("rd_popped", {63'd0, rsp_valid_o}, 64'd0);

    // Back-to-back writes, then reads under backpressure.
    got_q.delete();
    send(1'b1, 6'd1, 64'h11);
    send(1'b1, 6'd2, 64'h22);
    send(1'b1, 6'd3, 64'h33);
    send(1'b0, 6'd1, 64'd0);
    send(1'b0, 6'd2, 64'd0);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = 6'd3;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", {63'd0, cmd_ready_o}, 64'd0);
      step();
    end
    check("bp_head_valid", {63'd0, rsp_valid_o}, 64'd1);
    check("bp_head_data",  rsp_data_o,           64'h11);
    rsp_ready_i = 1'b1;
    begin
      int budget = 20;
      while (!cmd_ready_o && budget > 0) begin
        step();
        budget--;
      end
      check("bp_third_accept", {63'd0, cmd_ready_o}, 64'd1);
    end
    step();
    cmd_valid_i = 1'b0;
    repeat (8) step();
    rsp_ready_i = 1'b0;
    check("bp_rsp_count", 64'(got_q.size()), 64'd3);
    check("bp_rsp0", got_at(0), 64'h11);
    check("bp_rsp1", got_at(1), 64'h22);
    check("bp_rsp2", got_at(2), 64'h33);

    // Full FIFO, single-cycle pop.
    got_q.delete();
    send(1'b0, 6'd1, 64'd0);
    send(1'b0, 6'd2, 64'd0);
    repeat (3) step();
    check("full_ready_low", {63'd0, cmd_ready_o}, 64'd0);
    check("full_head",      rsp_data_o,           64'h11);
    rsp_ready_i = 1'b1;
    #1;
    check("pop_same_cycle_ready", {63'd0, cmd_ready_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    check("pop_ready_rises", {63'd0, cmd_ready_o}, 64'd1);
    check("pop_next_head",   rsp_data_o,           64'h22);
    check("pop_valid",       {63'd0, rsp_valid_o}, 64'd1);
    repeat (3) step();
    check("pop_once_count", 64'(got_q.size()), 64'd1);
    check("pop_once_data",  got_at(0),         64'h11);
    rsp_ready_i = 1'b1;
    repeat (2) step();
    rsp_ready_i = 1'b0;
    check("drain_count", 64'(got_q.size()), 64'd2);
    check("drain_data",  got_at(1),         64'h22);
    check("drain_empty", {63'd0, rsp_valid_o}, 64'd0);

    // Reset with two reads in flight.
    got_q.delete();
    send(1'b0, 6'd1, 64'd0);
    send(1'b0, 6'd2, 64'd0);
    check("inflight_rd_en", {63'd0, mem_rd_en_o}, 64'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rst_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("mid_rst_rd_en", {63'd0, mem_rd_en_o}, 64'd0);
    check("mid_rst_ready", {63'd0, cmd_ready_o}, 64'd0);
    rsp_ready_i = 1'b1;
    wait_init();
    repeat (4) step();
    check("no_stale_rsp", 64'(got_q.size()), 64'd0);
    send(1'b1, 6'd63, 64'hA5A55A5A0F0FF0F0);
    send(1'b0, 6'd63, 64'd0);
    repeat (4) step();
    rsp_ready_i = 1'b0;
    check("post_rst_count", 64'(got_q.size()), 64'd1);
    check("post_rst_data",  got_at(0),         64'hA5A55A5A0F0FF0F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
